// File: rtl/inst_loader.sv
// ---------------------------------------------------------------------------
// inst_loader
//   Writer side of the instruction-fetch path. Each accepted host command
//   (alu code, rs, rt, rd) is encoded into a 32-bit R-type instruction word.
//   The word is written to the next instruction-memory address and then read
//   back and compared. A mismatch sets a sticky error flag, so a bad program
//   image is caught before the CPU leaves reset.
//
// Ports
//   Clk        : system clock, rising edge
//   Rst        : asynchronous active-low reset
//   clear      : sync; pointer -> BASE, count -> 0, leaves FULL/ERR
//                (only sampled in IDLE/FULL/ERR)
//   cmd_valid  : host offers a command
//   cmd_ready  : loader accepts a command this cycle
//   cmd_alu    : 3-bit ALU op code
//   cmd_rs/rt/rd : register fields
//   mem_we     : write strobe, one cycle per word
//   mem_re     : read-back strobe
//   mem_addr   : word address (held at the load pointer while idle)
//   mem_wdata  : encoded instruction (held until the next accept)
//   mem_rdata  : read data, valid the cycle after mem_re
//   count      : words loaded and verified
//   full       : count == DEPTH
//   err        : sticky verify mismatch
// ---------------------------------------------------------------------------
module inst_loader #(
    parameter int AW    = 5,
    parameter int DEPTH = 32,
    parameter int BASE  = 0
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          clear,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_alu,
    input  logic [4:0]    cmd_rs,
    input  logic [4:0]    cmd_rt,
    input  logic [4:0]    cmd_rd,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err
);

    localparam logic [AW-1:0] BASE_A  = AW'(BASE);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_CHECK,
        S_FULL,
        S_ERR
    } state_t;

    state_t      state;
    logic [AW:0] count_inc;

    // Map the CPU's ALU op code to the R-type func field.
    function automatic logic [5:0] alu_func(input logic [2:0] alu);
        logic [5:0] f;
        case (alu)
            3'b100: f = 6'b100000;
            3'b101: f = 6'b100010;
            3'b000: f = 6'b100100;
            3'b001: f = 6'b100101;
            3'b010: f = 6'b100110;
            3'b011: f = 6'b100111;
            3'b110: f = 6'b101011;
            3'b111: f = 6'b000100;
        endcase
        return f;
    endfunction

    // Ready is gated by the raw reset so it stays low while Rst is held,
    // and by clear so a simultaneous command is never accepted.
    always_comb begin
        cmd_ready = Rst && (state == S_IDLE) && !full && !err && !clear;
        count_inc = count + 1'b1;
    end

    // mem_addr doubles as the load pointer: it always equals BASE + count
    // (mod 2**AW) outside of an active transfer.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= S_IDLE;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= BASE_A;
            mem_wdata <= '0;
            count     <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear) begin
                        mem_addr <= BASE_A;
                        count    <= '0;
                    end else if (cmd_valid && cmd_ready) begin
                        mem_wdata <= {6'b000000, cmd_rs, cmd_rt, cmd_rd,
                                      5'b00000, alu_func(cmd_alu)};
                        mem_we    <= 1'b1;
                        state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    mem_re <= 1'b1;
                    state  <= S_READ;
                end
                S_READ: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (mem_rdata == mem_wdata) begin
                        mem_addr <= mem_addr + 1'b1;
                        count    <= count_inc;
                        if (count_inc == DEPTH_C) begin
                            full  <= 1'b1;
                            state <= S_FULL;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        err   <= 1'b1;
                        state <= S_ERR;
                    end
                end
                S_FULL: begin
                    if (clear) begin
                        full     <= 1'b0;
                        mem_addr <= BASE_A;
                        count    <= '0;
                        state    <= S_IDLE;
                    end
                end
                S_ERR: begin
                    if (clear) begin
                        err      <= 1'b0;
                        mem_addr <= BASE_A;
                        count    <= '0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
